// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its branch history table.
// The optional BRU_STATS_EN build adds branch/mispredict counters to the top.
package bru_pkg;

  localparam int BHT_DEPTH = 64;
  localparam int BHT_IDX_W = 6;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // 010/011 are not real branches: they resolve not-taken and never train the BHT.
  function automatic logic br_cond_valid(input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic br_cond_taken(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt,
                                         input logic       ltu);
    logic tk;
    tk = 1'b0;
    case (funct3)
      F3_BEQ:  tk = eq;
      F3_BNE:  tk = ~eq;
      F3_BLT:  tk = lt;
      F3_BGE:  tk = ~lt;
      F3_BLTU: tk = ltu;
      F3_BGEU: tk = ~ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2-bit saturating counters with one combinational read port
// and one clocked update port; a read of an index being updated returns the old value.
module bht_2bit
  import bru_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  bht_ctr_t ctr_q [BHT_DEPTH];
  bht_ctr_t rd_ctr;

  always_comb begin
    rd_ctr   = ctr_q[rd_idx];
    rd_taken = rd_ctr[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps, raises a one-cycle registered flush with redirect PC,
// and trains the BHT. Define BRU_STATS_EN to add br_count / mispredict_count outputs.
module branch_resolve_unit
  import bru_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_br_target,
  input  logic [31:0] ex_jalr_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        flush,
  output logic [31:0] redirect_pc
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispredict_count
`endif
);

  // ex_valid qualifies the EX instruction for exactly one cycle; there is no backpressure.
  // While flush is high the EX instruction is a squashed wrong-path op and is dropped.
  logic        accept;
  logic        is_cond;
  logic        taken;
  logic [31:0] pc_plus4;
  logic        flush_d;
  logic [31:0] redirect_d;
  logic        bht_upd;
  logic        unused_bits;

  assign unused_bits = ^{if_pc[31:8], if_pc[1:0], ex_jalr_target[0]};

  always_comb begin
    accept     = ex_valid & ~flush;
    is_cond    = br_cond_valid(ex_funct3);
    taken      = br_cond_taken(ex_funct3, br_eq, br_lt, br_ltu);
    pc_plus4   = ex_pc + 32'd4;
    flush_d    = 1'b0;
    redirect_d = redirect_pc;
    bht_upd    = 1'b0;
    if (accept) begin
      if (ex_is_jal) begin
        flush_d    = 1'b1;
        redirect_d = ex_br_target;
      end else if (ex_is_jalr) begin
        flush_d    = 1'b1;
        redirect_d = {ex_jalr_target[31:1], 1'b0};
      end else if (ex_is_branch) begin
        bht_upd = is_cond;
        if (taken != ex_pred_taken) begin
          flush_d    = 1'b1;
          redirect_d = taken ? ex_br_target : pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      flush       <= flush_d;
      redirect_pc <= redirect_d;
    end
  end

  bht_2bit u_bht (
    .clk       (CLK),
    .rst       (RST),
    .rd_idx    (if_pc[7:2]),
    .rd_taken  (if_pred_taken),
    .upd_en    (bht_upd),
    .upd_idx   (ex_pc[7:2]),
    .upd_taken (taken)
  );

`ifdef BRU_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count         <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (bht_upd) br_count <= br_count + 32'd1;
      if (flush_d) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule
